// File: rtl/blackjack_hand_sequencer.sv
// blackjack_hand_sequencer
//
// Plays one blackjack hand under dealer rules. Cards come from a card source
// over a req/valid handshake. The sequencer tracks the best hand total, with
// soft-ace handling, and stands once the total reaches STAND_AT. With
// HIT_SOFT_17 set it hits on soft 17 instead of standing.
//
// Ports
//   clock_i         system clock, rising edge
//   reset_i         synchronous active-high reset, aborts any hand
//   start_i         begin a new hand (honoured in IDLE or DONE only)
//   card_valid_i    card_value_i is valid this cycle
//   card_value_i    rank code: 1 ace, 2..10 pip, 11..13 face; 0/14/15 illegal
//   card_req_o      card requested (high in REQ)
//   hand_total_o    current best total
//   soft_o          an ace is currently counted as 11
//   card_count_o    cards accepted this hand, saturating at 15
//   busy_o          hand in progress
//   done_o          hand finished, held until start or reset
//   bust_o          final total exceeded 21
//   blackjack_o     21 made with exactly two cards
//   illegal_card_o  one-cycle pulse after an illegal code was offered
//
// state | meaning
// IDLE  | waiting for start after reset
// REQ   | requesting a card, waiting for card_valid_i
// ADD   | add the latched card into the total
// CHECK | decide bust / stand / hit
// DONE  | hand finished, results held until start
module blackjack_hand_sequencer #(
  parameter int STAND_AT    = 17,
  parameter bit HIT_SOFT_17 = 1'b0
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       card_valid_i,
  input  logic [3:0] card_value_i,
  output logic       card_req_o,
  output logic [4:0] hand_total_o,
  output logic       soft_o,
  output logic [3:0] card_count_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       bust_o,
  output logic       blackjack_o,
  output logic       illegal_card_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_ADD   = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [4:0] STAND_AT_W = 5'(STAND_AT);

  logic [2:0] state_q, state_d;
  logic [4:0] total_q, total_d;
  logic       soft_q, soft_d;
  logic [3:0] count_q, count_d;
  logic [3:0] card_q, card_d;
  logic       bust_q, bust_d;
  logic       bj_q, bj_d;
  logic       illegal_q, illegal_d;

  logic       card_legal;
  logic       is_ace;
  logic [3:0] card_w;
  logic       ace_as_11;
  logic [5:0] add_w;
  logic [5:0] sum_raw;
  logic       soft_add;
  logic [5:0] sum_fix;
  logic       soft_fix;
  logic       stand;

  assign card_legal = (card_value_i >= 4'd1) && (card_value_i <= 4'd13);

  // Weight of the latched card with aces taken as 1; faces count 10.
  assign is_ace = (card_q == 4'd1);
  assign card_w = (card_q >= 4'd11) ? 4'd10 : card_q;

  // An ace is counted as 11 only if no ace is already soft and it fits.
  assign ace_as_11 = is_ace && !soft_q && (({1'b0, total_q} + 6'd11) <= 6'd21);
  assign add_w     = ace_as_11 ? 6'd11 : {2'b00, card_w};
  assign sum_raw   = {1'b0, total_q} + add_w;
  assign soft_add  = soft_q | ace_as_11;

  // Going over 21 with a soft ace: demote that ace to 1. One demotion suffices
  // because a soft total is at most 21 and a card adds at most 10 here.
  always_comb begin
    sum_fix  = sum_raw;
    soft_fix = soft_add;
    if (sum_raw > 6'd21 && soft_add) begin
      sum_fix  = sum_raw - 6'd10;
      soft_fix = 1'b0;
    end
  end

  assign stand = (total_q >= STAND_AT_W) &&
                 !(HIT_SOFT_17 && (total_q == 5'd17) && soft_q);

  always_comb begin
    state_d   = state_q;
    total_d   = total_q;
    soft_d    = soft_q;
    count_d   = count_q;
    card_d    = card_q;
    bust_d    = bust_q;
    bj_d      = bj_q;
    illegal_d = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d = S_REQ;
          total_d = 5'd0;
          soft_d  = 1'b0;
          count_d = 4'd0;
          bust_d  = 1'b0;
          bj_d    = 1'b0;
        end
      end
      S_REQ: begin
        if (card_valid_i) begin
          if (card_legal) begin
            card_d  = card_value_i;
            count_d = (count_q == 4'd15) ? 4'd15 : count_q + 4'd1;
            state_d = S_ADD;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      S_ADD: begin
        total_d = sum_fix[4:0];
        soft_d  = soft_fix;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (total_q > 5'd21) begin
          bust_d  = 1'b1;
          state_d = S_DONE;
        end else if (stand) begin
          bj_d    = (total_q == 5'd21) && (count_q == 4'd2);
          state_d = S_DONE;
        end else begin
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      total_q   <= 5'd0;
      soft_q    <= 1'b0;
      count_q   <= 4'd0;
      card_q    <= 4'd0;
      bust_q    <= 1'b0;
      bj_q      <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      total_q   <= total_d;
      soft_q    <= soft_d;
      count_q   <= count_d;
      card_q    <= card_d;
      bust_q    <= bust_d;
      bj_q      <= bj_d;
      illegal_q <= illegal_d;
    end
  end

  assign card_req_o     = (state_q == S_REQ);
  assign busy_o         = (state_q == S_REQ) || (state_q == S_ADD) || (state_q == S_CHECK);
  assign done_o         = (state_q == S_DONE);
  assign hand_total_o   = total_q;
  assign soft_o         = soft_q;
  assign card_count_o   = count_q;
  assign bust_o         = bust_q;
  assign blackjack_o    = bj_q;
  assign illegal_card_o = illegal_q;

endmodule

// File: tb/tb_blackjack_hand_sequencer.sv
// Testbench for blackjack_hand_sequencer: two instances (stand on soft 17 and
// hit on soft 17) share the card bus; one is selected at a time. Hands are
// scored by a card-list model: hard sum with aces as 1, plus 10 if an ace
// exists and the result stays within 21.
module tb_blackjack_hand_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_a, start_b;
  logic       card_valid;
  logic [3:0] card_value;

  logic       req_a, soft_a, busy_a, done_a, bust_a, bj_a, ill_a;
  logic [4:0] total_a;
  logic [3:0] count_a;
  logic       req_b, soft_b, busy_b, done_b, bust_b, bj_b, ill_b;
  logic [4:0] total_b;
  logic [3:0] count_b;

  logic       req_o, soft_o, busy_o, done_o, bust_o, bj_o, ill_o;
  logic [4:0] total_o;
  logic [3:0] count_o;

  bit sel;
  int errors = 0;
  int checks = 0;
  int deck_q[$];
  int ill_q[$];

  always #5 clk = ~clk;

  blackjack_hand_sequencer u_dut (
    .clock_i(clk), .reset_i(rst), .start_i(start_a),
    .card_valid_i(card_valid), .card_value_i(card_value),
    .card_req_o(req_a), .hand_total_o(total_a), .soft_o(soft_a),
    .card_count_o(count_a), .busy_o(busy_a), .done_o(done_a),
    .bust_o(bust_a), .blackjack_o(bj_a), .illegal_card_o(ill_a)
  );

  blackjack_hand_sequencer #(.STAND_AT(17), .HIT_SOFT_17(1'b1)) u_dut_h17 (
    .clock_i(clk), .reset_i(rst), .start_i(start_b),
    .card_valid_i(card_valid), .card_value_i(card_value),
    .card_req_o(req_b), .hand_total_o(total_b), .soft_o(soft_b),
    .card_count_o(count_b), .busy_o(busy_b), .done_o(done_b),
    .bust_o(bust_b), .blackjack_o(bj_b), .illegal_card_o(ill_b)
  );

  always_comb begin
    req_o   = sel ? req_b   : req_a;
    soft_o  = sel ? soft_b  : soft_a;
    busy_o  = sel ? busy_b  : busy_a;
    done_o  = sel ? done_b  : done_a;
    bust_o  = sel ? bust_b  : bust_a;
    bj_o    = sel ? bj_b    : bj_a;
    ill_o   = sel ? ill_b   : ill_a;
    total_o = sel ? total_b : total_a;
    count_o = sel ? count_b : count_a;
  end

  task automatic chk_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (sel=%0d t=%0t)", tag, obs, exp, sel, $time);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk_eq({tag, " total"}, int'(total_o), 0);
    chk_eq({tag, " soft"}, int'(soft_o), 0);
    chk_eq({tag, " count"}, int'(count_o), 0);
    chk_eq({tag, " req"}, int'(req_o), 0);
    chk_eq({tag, " busy"}, int'(busy_o), 0);
    chk_eq({tag, " done"}, int'(done_o), 0);
    chk_eq({tag, " bust"}, int'(bust_o), 0);
    chk_eq({tag, " bj"}, int'(bj_o), 0);
    chk_eq({tag, " illegal"}, int'(ill_o), 0);
  endtask

  // Pulses start on the selected instance; leaves the bench at a negedge.
  task automatic start_hand();
    @(negedge clk);
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    chk_eq("start req", int'(req_o), 1);
    chk_eq("start busy", int'(busy_o), 1);
    chk_eq("start done", int'(done_o), 0);
    chk_eq("start total", int'(total_o), 0);
    chk_eq("start count", int'(count_o), 0);
    chk_eq("start soft", int'(soft_o), 0);
    chk_eq("start bust", int'(bust_o), 0);
    chk_eq("start bj", int'(bj_o), 0);
  endtask

  // Called at a negedge; presents a code for one edge.
  task automatic drive_card(input int c);
    card_valid = 1'b1;
    card_value = 4'(c);
    @(posedge clk);
    #1;
    card_valid = 1'b0;
    card_value = 4'($urandom_range(0, 15));
  endtask

  task automatic wait_req();
    int n = 0;
    @(negedge clk);
    while (!req_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_o) chk_eq("wait_req timeout", int'(req_o), 1);
  endtask

  // Feeds one legal card; lat returns the cycle index (acceptance cycle = 0)
  // at which card_req or done is next seen. Leaves the bench at a negedge.
  task automatic feed_card(input int c, output int lat);
    drive_card(c);
    lat = 1;
    @(negedge clk);
    while (!(req_o || done_o) && lat < 10) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic offer_illegal(input int code, input int n_exp);
    drive_card(code);
    @(negedge clk);
    chk_eq("illegal pulse", int'(ill_o), 1);
    chk_eq("illegal count", int'(count_o), n_exp);
    chk_eq("illegal req", int'(req_o), 1);
    @(negedge clk);
    chk_eq("illegal one-cycle", int'(ill_o), 0);
    chk_eq("illegal req hold", int'(req_o), 1);
  endtask

  task automatic play_hand(input bit use_rand);
    int hard = 0;
    int aces = 0;
    int n = 0;
    int best = 0;
    int lat, c;
    bit soft_m = 1'b0;
    bit fin = 1'b0;
    int ill_codes[3] = '{0, 14, 15};
    start_hand();
    while (!fin && n < 20) begin
      while (ill_q.size() > 0) offer_illegal(ill_q.pop_front(), n);
      if (use_rand && $urandom_range(0, 5) == 0)
        offer_illegal(ill_codes[$urandom_range(0, 2)], n);
      c = (deck_q.size() > 0) ? deck_q.pop_front() : int'($urandom_range(1, 13));
      feed_card(c, lat);
      n++;
      hard += (c >= 10) ? 10 : c;
      if (c == 1) aces++;
      soft_m = (aces > 0) && (hard + 10 <= 21);
      best   = soft_m ? hard + 10 : hard;
      fin    = (best > 21) || (best >= 17 && !(sel && best == 17 && soft_m));
      chk_eq("latency", lat, 3);
      chk_eq("total", int'(total_o), best);
      chk_eq("soft", int'(soft_o), int'(soft_m));
      chk_eq("count", int'(count_o), (n > 15) ? 15 : n);
      chk_eq("done", int'(done_o), int'(fin));
      chk_eq("req", int'(req_o), int'(!fin));
    end
    chk_eq("bust", int'(bust_o), int'(best > 21));
    chk_eq("blackjack", int'(bj_o), int'(best == 21 && n == 2));
    @(negedge clk);
    chk_eq("done held", int'(done_o), 1);
    chk_eq("total held", int'(total_o), best);
  endtask

  initial begin
    int lat;
    rst = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    card_valid = 1'b0;
    card_value = 4'd0;
    sel = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs("reset a");
    sel = 1'b1;
    chk_reset_outputs("reset b");
    sel = 1'b0;

    // Directed hands on the stand-on-soft-17 instance.
    deck_q = '{10, 7};        play_hand(1'b0);
    deck_q = '{1, 13};        play_hand(1'b0);
    deck_q = '{5, 6, 10};     play_hand(1'b0);
    deck_q = '{10, 6, 9};     play_hand(1'b0);
    deck_q = '{1, 5, 10, 1};  play_hand(1'b0);
    deck_q = '{1, 6};         play_hand(1'b0);
    ill_q  = '{0, 14};
    deck_q = '{9, 8};         play_hand(1'b0);

    // Hit-on-soft-17 instance.
    sel = 1'b1;
    deck_q = '{1, 6, 10};     play_hand(1'b0);
    deck_q = '{1, 1, 5};      play_hand(1'b0);
    sel = 1'b0;

    // Reset while the second card is being added.
    start_hand();
    drive_card(10);
    wait_req();
    drive_card(4);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs("reset in ADD");

    // Start during ADD, CHECK and REQ is ignored; start in DONE restarts.
    start_hand();
    drive_card(10);
    start_a = 1'b1;
    repeat (3) @(posedge clk);
    #1 start_a = 1'b0;
    @(negedge clk);
    chk_eq("ignored start total", int'(total_o), 10);
    chk_eq("ignored start count", int'(count_o), 1);
    chk_eq("ignored start req", int'(req_o), 1);
    feed_card(7, lat);
    chk_eq("ignored start final", int'(total_o), 17);
    chk_eq("ignored start done", int'(done_o), 1);
    deck_q = '{9, 9};         play_hand(1'b0);

    // Randomized hands on both instances.
    for (int i = 0; i < 60; i++) begin
      sel = (i % 2) == 1;
      play_hand(1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
